// File: rtl/vx_gpr_sched_if.sv
// rtl/vx_gpr_sched_if.sv - operand-read request/response bundle for vx_gpr_sched
interface vx_gpr_sched_if #(
   parameter int NUM_REQS = 4,
   parameter int BANKW    = 2,
   parameter int ADDRW    = 6
);
   logic [NUM_REQS-1:0]       req_valid;
   logic [NUM_REQS*BANKW-1:0] req_bank;
   logic [NUM_REQS*ADDRW-1:0] req_addr;
   logic [NUM_REQS-1:0]       req_ready;
   logic [NUM_REQS-1:0]       rsp_valid;
   logic [NUM_REQS*BANKW-1:0] rsp_bank;

   modport master (
      output req_valid, req_bank, req_addr,
      input  req_ready, rsp_valid, rsp_bank
   );

   modport slave (
      input  req_valid, req_bank, req_addr,
      output req_ready, rsp_valid, rsp_bank
   );
endinterface

// File: rtl/vx_gpr_sched.sv
// rtl/vx_gpr_sched.sv - banked GPR read scheduler with round-robin per bank and clear pass
module vx_gpr_sched #(
   parameter int NUM_REQS  = 4,
   parameter int NUM_BANKS = 4,
   parameter int ADDRW     = 6,
   parameter int LATENCY   = 1,
   parameter int PERF_W    = 44
) (
   input  logic                       clk,
   input  logic                       reset,
   vx_gpr_sched_if.slave              req_if,
   input  logic                       reinit,
   output logic [NUM_BANKS-1:0]       bank_rd_en,
   output logic [NUM_BANKS*ADDRW-1:0] bank_rd_addr,
   output logic                       bank_wr_en,
   output logic [ADDRW-1:0]           bank_wr_addr,
   output logic                       init_done,
   output logic [PERF_W-1:0]          collisions
);
   localparam int BANKW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
   localparam int REQW  = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
   localparam int CNTW  = $clog2(NUM_REQS + 1);
   localparam int SUMW  = ((PERF_W > CNTW) ? PERF_W : CNTW) + 1;

   localparam logic [1:0] ST_INIT  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   logic [1:0]                state;
   logic [ADDRW-1:0]          cnt;
   logic [REQW-1:0]           ptr [NUM_BANKS];
   logic [REQW-1:0]           winner [NUM_BANKS];
   logic [NUM_BANKS-1:0]      bank_hit;
   logic [NUM_REQS-1:0]       grant;
   logic [NUM_REQS*BANKW-1:0] grant_bank;
   logic [NUM_REQS-1:0]       pipe_valid [LATENCY];
   logic [NUM_REQS*BANKW-1:0] pipe_bank [LATENCY];
   logic                      in_flight;
   logic [CNTW-1:0]           stall_cnt;
   logic [SUMW-1:0]           coll_sum;
   logic                      run;

   assign run = (state == ST_RUN) && !reset;

   // Each bank scans upward from ptr+1; a requester names one bank, so grants never overlap.
   always_comb begin
      int r;
      r            = 0;
      grant        = '0;
      bank_hit     = '0;
      bank_rd_addr = '0;
      grant_bank   = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         winner[b] = ptr[b];
         for (int i = 1; i <= NUM_REQS; i++) begin
            r = (int'(ptr[b]) + i) % NUM_REQS;
            if (run && !bank_hit[b] && req_if.req_valid[r]
                && (NUM_BANKS == 1 || int'(req_if.req_bank[r*BANKW +: BANKW]) == b)) begin
               bank_hit[b]                        = 1'b1;
               winner[b]                          = REQW'(r);
               grant[r]                           = 1'b1;
               bank_rd_addr[b*ADDRW +: ADDRW]     = req_if.req_addr[r*ADDRW +: ADDRW];
               grant_bank[r*BANKW +: BANKW]       = BANKW'(b);
            end
         end
      end
   end

   always_comb begin
      stall_cnt = '0;
      for (int r = 0; r < NUM_REQS; r++) begin
         if (req_if.req_valid[r] && !grant[r]) stall_cnt = stall_cnt + CNTW'(1);
      end
   end

   always_comb begin
      in_flight = 1'b0;
      for (int s = 0; s < LATENCY; s++) in_flight = in_flight | (|pipe_valid[s]);
   end

   assign coll_sum         = SUMW'(collisions) + SUMW'(stall_cnt);
   assign req_if.req_ready = grant;
   assign req_if.rsp_valid = reset ? '0 : pipe_valid[LATENCY-1];
   assign req_if.rsp_bank  = pipe_bank[LATENCY-1];
   assign bank_rd_en       = bank_hit;
   assign bank_wr_en       = (state == ST_INIT) && !reset;
   assign bank_wr_addr     = cnt;
   assign init_done        = run;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_INIT;
         cnt   <= '0;
      end else begin
         case (state)
            ST_INIT: begin
               cnt <= cnt + 1'b1;
               if (cnt == '1) state <= ST_RUN;
            end
            ST_RUN: begin
               if (reinit) state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (!in_flight) begin
                  state <= ST_INIT;
                  cnt   <= '0;
               end
            end
            default: state <= ST_INIT;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
         if (reset) ptr[b] <= REQW'(NUM_REQS - 1);
         else if (bank_hit[b]) ptr[b] <= winner[b];
      end
   end

   // Response pipe indexed by requester: grants never collide on a requester in one cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int s = 0; s < LATENCY; s++) begin
            pipe_valid[s] <= '0;
            pipe_bank[s]  <= '0;
         end
      end else begin
         pipe_valid[0] <= grant;
         pipe_bank[0]  <= grant_bank;
         for (int s = 1; s < LATENCY; s++) begin
            pipe_valid[s] <= pipe_valid[s-1];
            pipe_bank[s]  <= pipe_bank[s-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         collisions <= '0;
      end else if (run) begin
         if (coll_sum > SUMW'({PERF_W{1'b1}})) collisions <= '1;
         else collisions <= coll_sum[PERF_W-1:0];
      end
   end
endmodule

// File: tb/tb_vx_gpr_sched.sv
// tb/tb_vx_gpr_sched.sv - directed self-checking bench for vx_gpr_sched
module tb_vx_gpr_sched;
   localparam int NR = 4;
   localparam int NB = 4;
   localparam int AW = 6;
   localparam int BW = 2;

   logic clk = 1'b0;
   logic reset;
   logic reinit;
   always #5 clk = ~clk;

   vx_gpr_sched_if #(.NUM_REQS(NR), .BANKW(BW), .ADDRW(AW)) if_a ();
   vx_gpr_sched_if #(.NUM_REQS(NR), .BANKW(BW), .ADDRW(AW)) if_b ();

   assign if_b.req_valid = if_a.req_valid;
   assign if_b.req_bank  = if_a.req_bank;
   assign if_b.req_addr  = if_a.req_addr;

   logic [NB-1:0]    rd_en_a, rd_en_b;
   logic [NB*AW-1:0] rd_addr_a, rd_addr_b;
   logic             wr_en_a, wr_en_b;
   logic [AW-1:0]    wr_addr_a, wr_addr_b;
   logic             done_a, done_b;
   logic [43:0]      coll_a;
   logic [1:0]       coll_b;

   vx_gpr_sched #(.NUM_REQS(NR), .NUM_BANKS(NB), .ADDRW(AW), .LATENCY(1), .PERF_W(44)) dut_a (
      .clk(clk), .reset(reset), .req_if(if_a.slave), .reinit(reinit),
      .bank_rd_en(rd_en_a), .bank_rd_addr(rd_addr_a), .bank_wr_en(wr_en_a),
      .bank_wr_addr(wr_addr_a), .init_done(done_a), .collisions(coll_a)
   );

   vx_gpr_sched #(.NUM_REQS(NR), .NUM_BANKS(NB), .ADDRW(AW), .LATENCY(2), .PERF_W(2)) dut_b (
      .clk(clk), .reset(reset), .req_if(if_b.slave), .reinit(reinit),
      .bank_rd_en(rd_en_b), .bank_rd_addr(rd_addr_b), .bank_wr_en(wr_en_b),
      .bank_wr_addr(wr_addr_b), .init_done(done_b), .collisions(coll_b)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [3:0] v, input logic [7:0] banks, input logic [23:0] addrs);
      if_a.req_valid = v;
      if_a.req_bank  = banks;
      if_a.req_addr  = addrs;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int k;
      reset  = 1'b1;
      reinit = 1'b0;
      drive(4'hf, 8'he4, 24'd0);
      repeat (3) @(negedge clk);
      #1;
      check_val("rst_ready",   64'(if_a.req_ready), 64'd0);
      check_val("rst_rd_en",   64'(rd_en_a),        64'd0);
      check_val("rst_rsp",     64'(if_a.rsp_valid), 64'd0);
      check_val("rst_done",    64'(done_a),         64'd0);
      check_val("rst_wr_en",   64'(wr_en_a),        64'd0);

      // Clear pass: 64 writes, requests held but never accepted
      @(negedge clk);
      reset = 1'b0;
      drive(4'hf, 8'h00, 24'd0);
      #1;
      for (int i = 0; i < 64; i++) begin
         if (i > 0) begin
            @(negedge clk);
            #1;
         end
         check_val("init_wr_en",  64'(wr_en_a),        64'd1);
         check_val("init_addr",   64'(wr_addr_a),      64'(i));
         check_val("init_ready",  64'(if_a.req_ready), 64'd0);
         check_val("init_done",   64'(done_a),         64'd0);
      end
      @(negedge clk);
      drive(4'h0, 8'h00, 24'd0);
      #1;
      check_val("run_done_a",  64'(done_a),  64'd1);
      check_val("run_done_b",  64'(done_b),  64'd1);
      check_val("run_wr_en",   64'(wr_en_a), 64'd0);
      check_val("run_coll0",   64'(coll_a),  64'd0);

      // Requesters 0 and 1 contend for bank 2
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         drive(4'b0011, 8'h0a, {6'd0, 6'd0, 6'd7, 6'd5});
         #1;
         check_val("rr_ready",   64'(if_a.req_ready), (j % 2 == 0) ? 64'h1 : 64'h2);
         check_val("rr_rd_en",   64'(rd_en_a),        64'h4);
         check_val("rr_rd_addr", 64'(rd_addr_a[17:12]), (j % 2 == 0) ? 64'd5 : 64'd7);
         if (j > 0) begin
            check_val("rr_rsp_valid", 64'(if_a.rsp_valid), (j % 2 == 1) ? 64'h1 : 64'h2);
            check_val("rr_rsp_bank",  64'(if_a.rsp_bank[((j % 2 == 1) ? 0 : 2) +: 2]), 64'd2);
         end else begin
            check_val("rr_rsp_none", 64'(if_a.rsp_valid), 64'h0);
         end
      end
      @(negedge clk);
      drive(4'h0, 8'h00, 24'd0);
      #1;
      check_val("rr_rsp_last",  64'(if_a.rsp_valid), 64'h2);
      check_val("rr_rsp_bank1", 64'(if_a.rsp_bank[3:2]), 64'd2);
      check_val("coll_after4",  64'(coll_a), 64'd4);
      check_val("coll_sat_b",   64'(coll_b), 64'd3);

      // All four on bank 2 with ptr[2]=1: requester 2 wins
      @(negedge clk);
      drive(4'hf, 8'haa, 24'd0);
      #1;
      check_val("rr_from_ptr", 64'(if_a.req_ready), 64'h4);

      // Distinct banks: everyone granted at once
      @(negedge clk);
      drive(4'hf, 8'he4, {6'd13, 6'd12, 6'd11, 6'd10});
      #1;
      check_val("par_ready",   64'(if_a.req_ready), 64'hf);
      check_val("par_rd_en",   64'(rd_en_a),        64'hf);
      check_val("par_rd_addr", 64'(rd_addr_a),      64'({6'd13, 6'd12, 6'd11, 6'd10}));
      check_val("par_coll",    64'(coll_a),         64'd7);
      @(negedge clk);
      drive(4'h0, 8'h00, 24'd0);
      #1;
      check_val("par_coll_same", 64'(coll_a),         64'd7);
      check_val("par_rsp_valid", 64'(if_a.rsp_valid), 64'hf);
      check_val("par_rsp_bank",  64'(if_a.rsp_bank),  64'he4);

      // Reinit with a read in flight on the LATENCY=2 instance
      @(negedge clk);
      drive(4'h1, 8'h01, 24'd9);
      reinit = 1'b1;
      #1;
      check_val("ri_ready_b", 64'(if_b.req_ready), 64'h1);
      @(negedge clk);
      drive(4'h0, 8'h00, 24'd0);
      reinit = 1'b0;
      #1;
      check_val("drain_done_b", 64'(done_b),          64'd0);
      check_val("drain_wr_b",   64'(wr_en_b),         64'd0);
      check_val("drain_rsp0_b", 64'(if_b.rsp_valid),  64'h0);
      check_val("drain_ready",  64'(if_b.req_ready),  64'h0);
      @(negedge clk);
      drive(4'h1, 8'h01, 24'd9);
      #1;
      check_val("drain_rsp_b",   64'(if_b.rsp_valid),     64'h1);
      check_val("drain_rbank_b", 64'(if_b.rsp_bank[1:0]), 64'd1);
      check_val("drain_no_rd_b", 64'(rd_en_b),            64'h0);
      @(negedge clk);
      drive(4'h0, 8'h00, 24'd0);
      #1;
      k = 0;
      while (!wr_en_b && k < 8) begin
         @(negedge clk);
         #1;
         k++;
      end
      check_val("reinit_wr_b",   64'(wr_en_b),   64'd1);
      check_val("reinit_addr_b", 64'(wr_addr_b), 64'd0);
      k = 0;
      while (!(done_a && done_b) && k < 200) begin
         @(negedge clk);
         #1;
         k++;
      end
      check_val("rerun_done", 64'({done_a, done_b}), 64'h3);

      // Reset one cycle after a grant discards the response
      @(negedge clk);
      drive(4'h1, 8'h00, 24'd3);
      #1;
      check_val("rg_ready", 64'(if_a.req_ready), 64'h1);
      @(negedge clk);
      drive(4'h0, 8'h00, 24'd0);
      reset = 1'b1;
      #1;
      check_val("rg_rsp_in_rst", 64'(if_a.rsp_valid), 64'h0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check_val("rg_rsp_a",   64'(if_a.rsp_valid), 64'h0);
      check_val("rg_rsp_b",   64'(if_b.rsp_valid), 64'h0);
      check_val("rg_wr_en",   64'(wr_en_a),        64'd1);
      check_val("rg_wr_addr", 64'(wr_addr_a),      64'd0);
      check_val("rg_done",    64'(done_a),         64'd0);
      @(negedge clk);
      #1;
      check_val("rg_rsp_b_late", 64'(if_b.rsp_valid), 64'h0);
      check_val("rg_wr_addr1",   64'(wr_addr_a),      64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
